// File: rtl/ntt_butterfly_if.sv
// Valid/ready beat bus of ntt_butterfly_pipe: per-lane operands, mode and tag in;
// per-lane results, tag and in-flight occupancy out.
interface ntt_butterfly_if #(
    parameter int unsigned COEFF_WIDTH = 30,
    parameter int unsigned LANES       = 2,
    parameter int unsigned TAG_WIDTH   = 9
);
    localparam int unsigned BW = LANES * COEFF_WIDTH;

    logic                 in_valid;
    logic                 in_ready;
    logic [1:0]           in_mode;
    logic [BW-1:0]        in_a;
    logic [BW-1:0]        in_b;
    logic [BW-1:0]        in_w;
    logic [TAG_WIDTH-1:0] in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [BW-1:0]        out_u;
    logic [BW-1:0]        out_v;
    logic [TAG_WIDTH-1:0] out_tag;
    logic [2:0]           occupancy;

    modport master (
        output in_valid, in_mode, in_a, in_b, in_w, in_tag, out_ready,
        input  in_ready, out_valid, out_u, out_v, out_tag, occupancy
    );

    modport slave (
        input  in_valid, in_mode, in_a, in_b, in_w, in_tag, out_ready,
        output in_ready, out_valid, out_u, out_v, out_tag, occupancy
    );
endinterface

// File: rtl/ntt_butterfly_pipe.sv
// LANES-wide 4-stage modular butterfly (CT / GS / bypass) with valid/ready and tag sideband.
// Define NTT_BUTTERFLY_HALVE_EN to scale GS outputs by 2^-1 mod q.
module ntt_butterfly_pipe #(
    parameter int unsigned COEFF_WIDTH = 30,
    parameter int unsigned MODULUS     = 998244353,
    parameter int unsigned LANES       = 2,
    parameter int unsigned TAG_WIDTH   = 9,
    parameter int unsigned LATENCY     = 4
) (
    input logic           clk,
    input logic           rst,
    ntt_butterfly_if.slave bus
);
    localparam int unsigned W  = COEFF_WIDTH;
    localparam int unsigned W1 = COEFF_WIDTH + 1;
    localparam int unsigned W2 = COEFF_WIDTH + 2;
    localparam int unsigned PW = 2 * COEFF_WIDTH;
    localparam int unsigned MW = PW + 1;
    localparam int unsigned XW = 2 * PW + 1;
    localparam int unsigned BW = LANES * COEFF_WIDTH;

    localparam logic [1:0]    MODE_CT = 2'd0;
    localparam logic [1:0]    MODE_GS = 2'd1;
    localparam logic [W1-1:0] Q1      = W1'(MODULUS);
    localparam logic [W2-1:0] Q2      = W2'(MODULUS);
    localparam logic [PW-1:0] QP      = PW'(MODULUS);
    localparam logic [MW-1:0] MU      = (MW'(1) << PW) / MW'(MODULUS);
    localparam logic [2:0]    OCC_MAX = 3'(LATENCY);

    function automatic logic [W-1:0] add_mod(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W1-1:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= Q1) s = s - Q1;
        return W'(s);
    endfunction

    function automatic logic [W-1:0] sub_mod(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W1-1:0] d;
        d = {1'b0, x} - {1'b0, y};
        if (x < y) d = d + Q1;
        return W'(d);
    endfunction

    // Quotient estimate undershoots by at most 2, so two trims land in [0, q-1]
    function automatic logic [W-1:0] barrett(input logic [PW-1:0] x);
        logic [XW-1:0] xm;
        logic [PW-1:0] qhat;
        logic [W2-1:0] r;
        xm   = XW'(x) * XW'(MU);
        qhat = PW'(xm >> PW);
        r    = W2'(x - qhat * QP);
        if (r >= Q2) r = r - Q2;
        if (r >= Q2) r = r - Q2;
        return W'(r);
    endfunction

`ifdef NTT_BUTTERFLY_HALVE_EN
    function automatic logic [W-1:0] halve(input logic [W-1:0] x);
        logic [W1-1:0] s;
        s = x[0] ? ({1'b0, x} + Q1) : {1'b0, x};
        return W'(s >> 1);
    endfunction
`endif

    logic en;
    logic accept;
    logic pop;

    logic                    v1, v2, v3;
    logic [1:0]              m1, m2, m3;
    logic [TAG_WIDTH-1:0]    t1, t2, t3;
    logic [LANES-1:0][W-1:0] a1, b1, w1, a2, b2, a3, b3, r3;
    logic [LANES-1:0][PW-1:0] p2;

    logic [LANES-1:0][W-1:0]  a1_d, b1_d, r3_d;
    logic [LANES-1:0][PW-1:0] p2_d;
    logic [BW-1:0]            u_d, v_d;

    // Whole pipe advances only when the output slot is free or being drained
    assign en           = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = en;
    assign accept       = bus.in_valid && en;
    assign pop          = bus.out_valid && bus.out_ready;

    always_comb begin
        a1_d = '0;
        b1_d = '0;
        p2_d = '0;
        r3_d = '0;
        u_d  = '0;
        v_d  = '0;
        for (int k = 0; k < LANES; k++) begin
            // GS folds its add/sub in front of the multiplier; others pass a/b through
            if (bus.in_mode == MODE_GS) begin
                a1_d[k] = add_mod(bus.in_a[k*W +: W], bus.in_b[k*W +: W]);
                b1_d[k] = sub_mod(bus.in_a[k*W +: W], bus.in_b[k*W +: W]);
            end else begin
                a1_d[k] = bus.in_a[k*W +: W];
                b1_d[k] = bus.in_b[k*W +: W];
            end
            p2_d[k] = PW'(b1[k]) * PW'(w1[k]);
            r3_d[k] = barrett(p2[k]);
            case (m3)
                MODE_CT: begin
                    u_d[k*W +: W] = add_mod(a3[k], r3[k]);
                    v_d[k*W +: W] = sub_mod(a3[k], r3[k]);
                end
                MODE_GS: begin
`ifdef NTT_BUTTERFLY_HALVE_EN
                    u_d[k*W +: W] = halve(a3[k]);
                    v_d[k*W +: W] = halve(r3[k]);
`else
                    u_d[k*W +: W] = a3[k];
                    v_d[k*W +: W] = r3[k];
`endif
                end
                default: begin
                    u_d[k*W +: W] = a3[k];
                    v_d[k*W +: W] = b3[k];
                end
            endcase
        end
    end

    // Stage registers S1..S4; everything holds while the output is stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;  v2 <= 1'b0;  v3 <= 1'b0;
            m1 <= '0;    m2 <= '0;    m3 <= '0;
            t1 <= '0;    t2 <= '0;    t3 <= '0;
            a1 <= '0;    b1 <= '0;    w1 <= '0;
            a2 <= '0;    b2 <= '0;    p2 <= '0;
            a3 <= '0;    b3 <= '0;    r3 <= '0;
            bus.out_valid <= 1'b0;
            bus.out_tag   <= '0;
            bus.out_u     <= '0;
            bus.out_v     <= '0;
        end else if (en) begin
            v1 <= bus.in_valid;
            m1 <= bus.in_mode;
            t1 <= bus.in_tag;
            a1 <= a1_d;
            b1 <= b1_d;
            w1 <= bus.in_w;
            v2 <= v1;
            m2 <= m1;
            t2 <= t1;
            a2 <= a1;
            b2 <= b1;
            p2 <= p2_d;
            v3 <= v2;
            m3 <= m2;
            t3 <= t2;
            a3 <= a2;
            b3 <= b2;
            r3 <= r3_d;
            bus.out_valid <= v3;
            bus.out_tag   <= t3;
            bus.out_u     <= u_d;
            bus.out_v     <= v_d;
        end
    end

    // Beats in flight: accepted but not yet handed to the consumer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.occupancy <= '0;
        end else if (accept && !pop && (bus.occupancy != OCC_MAX)) begin
            bus.occupancy <= bus.occupancy + 3'd1;
        end else if (pop && !accept) begin
            bus.occupancy <= bus.occupancy - 3'd1;
        end
    end
endmodule
